// File: rtl/mux_rr_n_if.sv
// Stream bundle for mux_rr_n: N request channels merged onto a single
// tagged output stream. The slave view belongs to the multiplexer and the
// master view belongs to whatever drives the sources and sinks the output.
interface mux_rr_n_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = (N > 2) ? $clog2(N) : 1;

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_sel;
    logic           out_valid;
    logic           out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_sel,
        output out_valid
    );

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_sel,
        input  out_valid
    );
endinterface

// File: rtl/mux_rr_n.sv
// N-channel arbitrating multiplexer with a one-deep registered output.
// Concurrently valid sources are resolved by round-robin (MODE=0) or by
// fixed lowest-index priority (MODE=1); every output word carries the index
// of the channel that supplied it. A word is accepted whenever the output
// register is empty or is being drained on the same edge, so a continuously
// ready sink sees one word per cycle with no bubbles.
module mux_rr_n #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int MODE = 0
) (
    input logic        clk,
    input logic        rst_n,
    mux_rr_n_if.slave  bus
);
    localparam int SW = (N > 2) ? $clog2(N) : 1;

    // Output register stage and arbitration state.
    logic [W-1:0]  data_p0;
    logic [SW-1:0] sel_p0;
    logic          vld_p0;
    logic [SW-1:0] ptr;

    // Arbitration results for the current cycle.
    logic          load_en;
    logic [SW-1:0] start;
    logic [N-1:0]  grant;
    logic [SW-1:0] gnt_idx;
    logic          gnt_any;
    logic [W-1:0]  gnt_data;

    // Channel index reached by stepping 'off' places upward from 'base',
    // wrapping past N-1 back to 0 (valid for non-power-of-two N as well).
    function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] base,
                                               input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) begin
            s = s - N;
        end
        return s[SW-1:0];
    endfunction

    // Round-robin successor of a granted channel; N-1 wraps to 0.
    function automatic logic [SW-1:0] next_ptr(input logic [SW-1:0] idx);
        logic [SW-1:0] nxt;
        if (idx == SW'(N - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + 1'b1;
        end
        return nxt;
    endfunction

    // The register can take a word when empty or when its word leaves now.
    assign load_en = !vld_p0 || bus.out_ready;

    // Fixed priority is the round-robin search anchored permanently at 0.
    assign start = (MODE == 0) ? ptr : '0;

    // Scan upward from the start channel; the first valid request wins.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!gnt_any && bus.in_valid[wrap_idx(start, k)]) begin
                gnt_any = 1'b1;
                gnt_idx = wrap_idx(start, k);
            end
        end
        if (gnt_any) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    assign gnt_data = bus.in_data[gnt_idx*W +: W];

    // Only the granted channel is told it was taken, and only if the
    // register actually loads; nothing is accepted while reset is held.
    assign bus.in_ready = (rst_n && load_en) ? grant : '0;

    // Output valid and round-robin pointer advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            ptr    <= '0;
        end else if (load_en) begin
            vld_p0 <= gnt_any;
            if (gnt_any && (MODE == 0)) begin
                ptr <= next_ptr(gnt_idx);
            end
        end
    end

    // Output word and source tag; held when idle or stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p0 <= '0;
            sel_p0  <= '0;
        end else if (load_en && gnt_any) begin
            data_p0 <= gnt_data;
            sel_p0  <= gnt_idx;
        end
    end

    assign bus.out_data  = data_p0;
    assign bus.out_sel   = sel_p0;
    assign bus.out_valid = vld_p0;

endmodule

// File: tb/tb_mux_rr_n.sv
// Bench for mux_rr_n: a round-robin and a fixed-priority instance receive
// identical stimulus. Each has a reference arbiter and a scoreboard queue of
// expected {sel,data} words, pushed when a load is predicted and retired
// when the output handshake completes.
module tb_mux_rr_n;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic clk;
    logic rst_n;

    mux_rr_n_if #(.N(N), .W(W)) bus0 ();
    mux_rr_n_if #(.N(N), .W(W)) bus1 ();

    mux_rr_n #(.N(N), .W(W), .MODE(0)) dut_rr (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus0)
    );

    mux_rr_n #(.N(N), .W(W), .MODE(1)) dut_fp (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1)
    );

    int n_checks;
    int n_fail;

    // Reference state per instance: 0 = round-robin, 1 = fixed priority.
    int            m_ptr   [2];
    logic          m_valid [2];
    logic [SW+W-1:0] q0 [$];
    logic [SW+W-1:0] q1 [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic string tg(input int m, input string name);
        return $sformatf("%s_%s", (m == 0) ? "rr" : "fp", name);
    endfunction

    function automatic int ref_grant(input int m, input int p,
                                     input logic [N-1:0] v);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (m == 1) ? k : (p + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N*W-1:0] pack4(input logic [7:0] a3,
                                             input logic [7:0] a2,
                                             input logic [7:0] a1,
                                             input logic [7:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic int sb_size(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [SW+W-1:0] sb_front(input int m);
        return (m == 0) ? q0[0] : q1[0];
    endfunction

    task automatic sb_pop(input int m);
        if (m == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic sb_push(input int m, input logic [SW+W-1:0] e);
        if (m == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_ptr[m]   = 0;
            m_valid[m] = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    // Compare one instance against its reference for the current cycle,
    // then advance the reference to what the coming edge should produce.
    task automatic observe(input int m, input logic [N-1:0] rdy,
                           input logic ov, input logic [W-1:0] od,
                           input logic [SW-1:0] os, input logic [N-1:0] v,
                           input logic [N*W-1:0] d, input logic ordy);
        int              g;
        logic            le;
        logic [N-1:0]    er;
        logic [SW+W-1:0] e;
        logic [W-1:0]    gd;
        le = !m_valid[m] || ordy;
        g  = ref_grant(m, m_ptr[m], v);
        er = '0;
        if (le && g >= 0) er[g] = 1'b1;
        chk(tg(m, "in_ready"), 64'(rdy), 64'(er));
        chk(tg(m, "out_valid"), 64'(ov), 64'(m_valid[m]));
        if (ov) begin
            if (sb_size(m) == 0) begin
                chk(tg(m, "sb_underflow"), 64'(ov), 64'd0);
            end else begin
                e = sb_front(m);
                chk(tg(m, "out_data"), 64'(od), 64'(e[W-1:0]));
                chk(tg(m, "out_sel"), 64'(os), 64'(e[SW+W-1:W]));
                if (ordy) sb_pop(m);
            end
        end
        if (le) begin
            if (g >= 0) begin
                gd = d[g*W +: W];
                sb_push(m, {SW'(g), gd});
                m_valid[m] = 1'b1;
                if (m == 0) m_ptr[m] = (g + 1) % N;
            end else begin
                m_valid[m] = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive, settle, check both instances, clock.
    task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d,
                         input logic ordy);
        bus0.in_valid  = v;
        bus0.in_data   = d;
        bus0.out_ready = ordy;
        bus1.in_valid  = v;
        bus1.in_data   = d;
        bus1.out_ready = ordy;
        #1;
        observe(0, bus0.in_ready, bus0.out_valid, bus0.out_data,
                bus0.out_sel, v, d, ordy);
        observe(1, bus1.in_ready, bus1.out_valid, bus1.out_data,
                bus1.out_sel, v, d, ordy);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({"rr_", name, "_valid"}, 64'(bus0.out_valid), 64'd0);
        chk({"rr_", name, "_data"},  64'(bus0.out_data),  64'd0);
        chk({"rr_", name, "_sel"},   64'(bus0.out_sel),   64'd0);
        chk({"rr_", name, "_ready"}, 64'(bus0.in_ready),  64'd0);
        chk({"fp_", name, "_valid"}, 64'(bus1.out_valid), 64'd0);
        chk({"fp_", name, "_data"},  64'(bus1.out_data),  64'd0);
        chk({"fp_", name, "_sel"},   64'(bus1.out_sel),   64'd0);
        chk({"fp_", name, "_ready"}, 64'(bus1.in_ready),  64'd0);
    endtask

    logic [N*W-1:0] dall;
    int             exp_seq [6];
    int             exp_wrap [3];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus0.in_valid = '0; bus0.in_data = '0; bus0.out_ready = 1'b0;
        bus1.in_valid = '0; bus1.in_data = '0; bus1.out_ready = 1'b0;
        model_reset();
        exp_seq  = '{0, 1, 2, 3, 0, 1};
        exp_wrap = '{3, 0, 3};
        dall     = pack4(8'h33, 8'h22, 8'h11, 8'h00);

        // Reset state with every channel requesting.
        repeat (2) @(posedge clk);
        #1;
        bus0.in_valid = 4'b1111; bus1.in_valid = 4'b1111;
        bus0.out_ready = 1'b1;   bus1.out_ready = 1'b1;
        #1;
        chk_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single channel request.
        cycle(4'b0010, pack4(8'h00, 8'h00, 8'hA5, 8'h00), 1'b1);
        chk("rr_single_data", 64'(bus0.out_data), 64'hA5);
        chk("rr_single_sel",  64'(bus0.out_sel),  64'd1);
        chk("fp_single_sel",  64'(bus1.out_sel),  64'd1);

        // Round-robin fairness from pointer 0.
        cycle(4'b1000, dall, 1'b1);
        for (int i = 0; i < 6; i++) begin
            dall = dall + 32'h01010101;
            cycle(4'b1111, dall, 1'b1);
            chk("rr_seq_sel", 64'(bus0.out_sel), 64'(exp_seq[i]));
            chk("rr_seq_valid", 64'(bus0.out_valid), 64'd1);
        end

        // Backpressure: stalled output holds, then next grant follows.
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1111, dall, 1'b0);
            chk("rr_stall_sel", 64'(bus0.out_sel), 64'd1);
        end
        cycle(4'b1111, dall, 1'b1);
        chk("rr_release_sel", 64'(bus0.out_sel), 64'd2);

        // Wrap with sparse requests from pointer 3.
        cycle(4'b0100, pack4(8'hD3, 8'hC2, 8'hB1, 8'hA0), 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1001, pack4(8'hD3 + 8'(i), 8'hC2, 8'hB1, 8'hA0 + 8'(i)), 1'b1);
            chk("rr_wrap_sel", 64'(bus0.out_sel), 64'(exp_wrap[i]));
        end

        // Fixed priority behaviour.
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1111, pack4(8'h4D, 8'h4C, 8'h4B, 8'h40 + 8'(i)), 1'b1);
            chk("fp_prio_sel", 64'(bus1.out_sel), 64'd0);
        end
        cycle(4'b1000, pack4(8'h7E, 8'h00, 8'h00, 8'h00), 1'b1);
        chk("fp_top_sel",  64'(bus1.out_sel),  64'd3);
        chk("fp_top_data", 64'(bus1.out_data), 64'h7E);
        cycle(4'b0000, '0, 1'b1);
        chk("fp_idle_valid", 64'(bus1.out_valid), 64'd0);
        chk("rr_idle_valid", 64'(bus0.out_valid), 64'd0);

        // Reset mid-stream with a held word.
        cycle(4'b0000, '0, 1'b1);
        cycle(4'b0001, pack4(8'h00, 8'h00, 8'h00, 8'h5A), 1'b0);
        cycle(4'b1111, pack4(8'h13, 8'h12, 8'h11, 8'h10), 1'b0);
        chk("rr_held_data", 64'(bus0.out_data), 64'h5A);
        rst_n = 1'b0;
        bus0.out_ready = 1'b1; bus1.out_ready = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(4'b1111, pack4(8'h13, 8'h12, 8'h11, 8'h10), 1'b1);
        chk("rr_post_rst_sel",  64'(bus0.out_sel),  64'd0);
        chk("rr_post_rst_data", 64'(bus0.out_data), 64'h10);

        // Random traffic with random sink stalls.
        for (int i = 0; i < 300; i++) begin
            cycle(4'($urandom), 32'($urandom), ($urandom_range(0, 3) != 0));
        end
        cycle(4'b0000, '0, 1'b1);
        cycle(4'b0000, '0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
